led_anim_scheduler: RTL and testbench

Shares the 5-LED bar between several event sources in the game datapath. Each source raises a one-cycle request for a short LED animation. The block queues pending requests, grants one requester at a time by round-robin, and plays the selected pattern (fill, blink or chase) at a tick rate derived from `clk` by an enable prescaler. No derived clocks are used. It replaces ad-hoc per-event LED drivers and sits between the game control FSM and the board LED pins.

---
 rtl/led_anim_scheduler.sv | 146 ++++++++++++++
 tb/tb_led_anim_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_anim_scheduler.sv
// Round-robin scheduler that lends the LED bar to one requester at a time and plays FILL/BLINK/CHASE.
// Define LED_SCHED_PRIO0_EN to give requester 0 absolute priority whenever it is pending in IDLE.
module led_anim_scheduler #(
   parameter int NREQ     = 4,
   parameter int LED_W    = 5,
   parameter int TICK_DIV = 8388608
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [2*NREQ-1:0]   mode,
   output logic [LED_W-1:0]    led,
   output logic [NREQ-1:0]     grant,
   output logic                busy,
   output logic                done
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, PLAY} state_t;
   state_t state, state_next;

   logic [NREQ-1:0]  pending;
   logic [NREQ-1:0]  clr;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    winner;
   logic             found;
   logic [CW-1:0]    presc;
   logic [3:0]       step;
   logic [3:0]       nsteps;
   logic [1:0]       anim;
   logic [1:0]       mode_sel;
   logic             tick;
   logic             last_step;
   logic [LED_W-1:0] pattern;
   int               idx;

   assign busy  = (state != IDLE);
   assign grant = busy ? (NREQ'(1) << owner) : '0;
   assign clr   = (state == GRANT) ? grant : '0;
   assign tick  = (presc == CW'(TICK_DIV - 1));
   assign last_step = (step == nsteps - 4'd1);

   // Upward search from the pointer, wrapping; the first pending index wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && pending[PW'(idx)]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
`ifdef LED_SCHED_PRIO0_EN
      if (pending[0]) begin
         winner = '0;
      end
`endif
   end

   always_comb begin
      mode_sel = 2'b00;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == PW'(i)) begin
            mode_sel = mode[2*i +: 2];
         end
      end
   end

   // Mode 11 falls into the FILL branch; every pattern ends on an all-zero step.
   always_comb begin
      pattern = '0;
      nsteps  = 4'(LED_W + 1);
      case (anim)
         2'b01: begin
            nsteps = 4'd6;
            if (!step[0]) pattern = '1;
         end
         2'b10: begin
            if (int'(step) < LED_W) pattern = LED_W'(1) << step;
         end
         default: begin
            if (int'(step) < LED_W) pattern = LED_W'((32'd1 << (step + 4'd1)) - 32'd1);
         end
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = GRANT;
         GRANT:   state_next = PLAY;
         PLAY:    if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The GRANT cycle counts as prescaler cycle 0, so the first step lands TICK_DIV cycles after it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         pending <= '0;
         ptr     <= '0;
         owner   <= '0;
         presc   <= '0;
         step    <= '0;
         anim    <= '0;
         led     <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= (pending & ~clr) | req;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               presc <= '0;
               if (found) begin
                  owner <= winner;
                  ptr   <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
               end
            end
            GRANT: begin
               anim  <= mode_sel;
               presc <= CW'(1);
               step  <= '0;
            end
            PLAY: begin
               if (!done) begin
                  if (tick) begin
                     presc <= '0;
                     led   <= pattern;
                     step  <= step + 4'd1;
                     done  <= last_step;
                  end else begin
                     presc <= presc + CW'(1);
                  end
               end
            end
            default: presc <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_led_anim_scheduler.sv
// Self-checking bench for led_anim_scheduler: directed scenarios plus random traffic against a timing model.
// Honours LED_SCHED_PRIO0_EN the same way as the design.
module tb_led_anim_scheduler;
   localparam int NREQ     = 4;
   localparam int LED_W    = 5;
   localparam int TICK_DIV = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [NREQ-1:0]  req;
   logic [2*NREQ-1:0] mode;
   logic [LED_W-1:0] led;
   logic [NREQ-1:0]  grant;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   // Reference state: animation progress is tracked as cycles elapsed since the GRANT cycle.
   logic [NREQ-1:0] mPend = '0;
   int  mPtr    = 0;
   int  mOwner  = 0;
   int  mMode   = 0;
   int  mT      = 0;
   bit  mActive = 1'b0;

   logic [NREQ-1:0] prevGrant = '0;
   int order[$];
   int busyCount = 0;

   always #5 clk = ~clk;

   led_anim_scheduler #(.NREQ(NREQ), .LED_W(LED_W), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .reset(reset), .req(req), .mode(mode),
      .led(led), .grant(grant), .busy(busy), .done(done)
   );

   function automatic int stepsOf(int m);
      return (m == 1) ? 6 : LED_W + 1;
   endfunction

   function automatic logic [LED_W-1:0] pat(int m, int s);
      if (m == 1) return (s % 2 == 0) ? '1 : '0;
      if (s >= LED_W) return '0;
      if (m == 2) return LED_W'(1 << s);
      return LED_W'((1 << (s + 1)) - 1);
   endfunction

   function automatic int pick();
`ifdef LED_SCHED_PRIO0_EN
      if (mPend[0]) return 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (mPend[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic modelEdge(input logic r, input logic [NREQ-1:0] rq, input logic [2*NREQ-1:0] md);
      logic [NREQ-1:0] np;
      if (!r) begin
         mPend = '0; mPtr = 0; mActive = 1'b0; mT = 0;
         return;
      end
      np = mPend;
      if (mActive && mT == 0) np[mOwner] = 1'b0;
      np |= rq;
      if (!mActive) begin
         if (mPend != '0) begin
            mOwner  = pick();
            mPtr    = (mOwner + 1) % NREQ;
            mActive = 1'b1;
            mT      = 0;
         end
      end else if (mT == 0) begin
         mMode = int'(md[2*mOwner +: 2]);
         mT    = 1;
      end else if (mT == stepsOf(mMode) * TICK_DIV) begin
         mActive = 1'b0;
      end else begin
         mT++;
      end
      mPend = np;
   endtask

   task automatic checkOutput();
      logic [LED_W-1:0] expLed;
      logic [NREQ-1:0]  expGrant;
      logic             expBusy;
      logic             expDone;
      expBusy  = mActive;
      expGrant = mActive ? NREQ'(1 << mOwner) : '0;
      expDone  = mActive && mT > 0 && mT == stepsOf(mMode) * TICK_DIV;
      expLed   = (mActive && mT >= TICK_DIV) ? pat(mMode, mT / TICK_DIV - 1) : '0;
      checks += 4;
      assert (led === expLed) else begin
         errors++; $error("[TB] FAIL led: got %b expected %b", led, expLed);
      end
      assert (grant === expGrant) else begin
         errors++; $error("[TB] FAIL grant: got %b expected %b", grant, expGrant);
      end
      assert (busy === expBusy) else begin
         errors++; $error("[TB] FAIL busy: got %b expected %b", busy, expBusy);
      end
      assert (done === expDone) else begin
         errors++; $error("[TB] FAIL done: got %b expected %b", done, expDone);
      end
      if (grant != '0 && prevGrant == '0) begin
         for (int i = 0; i < NREQ; i++) if (grant[i]) order.push_back(i);
      end
      prevGrant = grant;
      if (busy === 1'b1) busyCount++;
   endtask

   task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic [2*NREQ-1:0] md);
      reset = r;
      req   = rq;
      mode  = md;
      @(posedge clk);
      modelEdge(r, rq, md);
      #1;
      checkOutput();
   endtask

   task automatic runCycles(input int n, input logic [2*NREQ-1:0] md);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, '0, md);
   endtask

   // Grant order encoded as decimal digits of (index+1), e.g. 0,1,2,3 -> 1234.
   task automatic checkOrder(input string tag, input int expCode);
      int got;
      got = 0;
      foreach (order[i]) got = got * 10 + order[i] + 1;
      checks++;
      assert (got === expCode) else begin
         errors++; $error("[TB] FAIL %s: got order code %0d expected %0d", tag, got, expCode);
      end
      order.delete();
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      mode  = '0;
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b0, '0, '0);
      order.delete();

      // Single FILL, busy window is GRANT plus six steps of TICK_DIV cycles
      busyCount = 0;
      applyStimulus(1'b1, 4'b0001, 8'h00);
      runCycles(30, 8'h00);
      checks++;
      assert (busyCount === 1 + 6 * TICK_DIV) else begin
         errors++; $error("[TB] FAIL fill_busy_len: got %0d expected %0d", busyCount, 1 + 6 * TICK_DIV);
      end
      checkOrder("fill_order", 1);

      // BLINK, CHASE and mode 11; mode is scrambled once PLAY has started
      applyStimulus(1'b1, 4'b0001, 8'h01);
      runCycles(2, 8'h01);
      runCycles(28, 8'hFE);
      applyStimulus(1'b1, 4'b0001, 8'h02);
      runCycles(2, 8'h02);
      runCycles(28, 8'h55);
      applyStimulus(1'b1, 4'b0001, 8'h03);
      runCycles(2, 8'h03);
      runCycles(28, 8'h00);
      order.delete();

      // Round-robin from pointer 0, then from pointer 2
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b1, 4'b1111, 8'h00);
      runCycles(110, 8'h00);
      checkOrder("rr_full", 1234);
      applyStimulus(1'b1, 4'b0010, 8'h00);
      runCycles(28, 8'h00);
      checkOrder("rr_ptr_setup", 2);
      applyStimulus(1'b1, 4'b0011, 8'h00);
      runCycles(56, 8'h00);
      checkOrder("rr_from_ptr2", 12);

      // Replay: request during own PLAY, then during own GRANT
      applyStimulus(1'b1, 4'b0010, 8'h20);
      runCycles(10, 8'h20);
      applyStimulus(1'b1, 4'b0010, 8'h20);
      runCycles(60, 8'h20);
      checkOrder("replay_play", 22);
      applyStimulus(1'b1, 4'b0010, 8'h00);
      runCycles(1, 8'h00);
      applyStimulus(1'b1, 4'b0010, 8'h00);
      runCycles(60, 8'h00);
      checkOrder("replay_grant", 22);

      // Mid-play reset with 2 owning and 3 pending, then only 3 requested
      applyStimulus(1'b1, 4'b1100, 8'h00);
      runCycles(14, 8'h00);
      applyStimulus(1'b0, 4'b0000, 8'h00);
      applyStimulus(1'b1, 4'b1000, 8'h00);
      runCycles(40, 8'h00);
      checkOrder("reset_recover", 34);

      // Pointer at 1, requesters 0..2 pending together
      applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b1, 4'b0001, 8'h00);
      runCycles(28, 8'h00);
      checkOrder("prio_setup", 1);
      applyStimulus(1'b1, 4'b0111, 8'h00);
      runCycles(84, 8'h00);
`ifdef LED_SCHED_PRIO0_EN
      checkOrder("prio_order", 123);
`else
      checkOrder("prio_order", 231);
`endif

      // Random traffic with occasional resets
      for (int i = 0; i < 2500; i++) begin
         applyStimulus(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                       ($urandom_range(0, 9) == 0) ? NREQ'($urandom) : '0,
                       (2*NREQ)'($urandom));
      end
      order.delete();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
